// File: rtl/md_sequencer.sv
// md_sequencer: RV32M multiply/divide sequencer for the EX stage.
// Registered multiply or 32-iteration restoring divide; md_stall holds the
// pipeline until the one-cycle md_valid strobe. flush aborts the op in flight.
// Optional macro MD_DIV_FASTPATH_EN: divide-by-zero and signed overflow skip
// the iterative loop and strobe one cycle after acceptance.
module md_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_req,
  input  logic [2:0]      md_operation,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            md_stall,
  output logic            md_busy,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [XLEN-1:0] spres_q, spres_d, result_q, result_d;
  logic [5:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d;
  logic            spec_q, spec_d, valid_q, valid_d;

  logic            div_signed, is_special;
  logic [XLEN-1:0] special_res, abs_a, abs_b;

  always_comb begin
    div_signed = ~md_operation[0];
    abs_a      = (div_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    abs_b      = (div_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
    is_special = (rs2_val == '0) ||
                 (div_signed && (rs1_val == INT_MIN) && (rs2_val == '1));
    if (rs2_val == '0) special_res = md_operation[1] ? rs1_val : '1;
    else               special_res = md_operation[1] ? '0 : INT_MIN;
  end

  // Signed 33x33 product, computed as 64-bit operands pre-extended from bit 32.
  logic                a_sx, b_sx;
  logic [2*XLEN-1:0]   mul_a, mul_b, prod;

  always_comb begin
    a_sx  = (op_q != 2'b11) & a_q[XLEN-1];
    b_sx  = ~op_q[1] & b_q[XLEN-1];
    mul_a = {{XLEN{a_sx}}, a_q};
    mul_b = {{XLEN{b_sx}}, b_q};
    prod  = mul_a * mul_b;
  end

  // One restoring-divide iteration; the remainder always fits XLEN bits
  // after a successful subtract, so the low-order difference is exact.
  logic [XLEN:0]   rem_sh;
  logic            step_ok;
  logic [XLEN-1:0] step_rem, step_quo, quo_fix, rem_fix;

  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    step_ok  = rem_sh >= {1'b0, b_q};
    step_rem = step_ok ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    step_quo = {quo_q[XLEN-2:0], step_ok};
    quo_fix  = qneg_q ? -step_quo : step_quo;
    rem_fix  = rneg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    spec_d   = spec_q;
    spres_d  = spres_q;
    valid_d  = 1'b0;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (md_req && !flush) begin
          op_d = md_operation[1:0];
          a_d  = rs1_val;
          b_d  = rs2_val;
          if (!md_operation[2]) begin
            state_d = MUL;
          end else begin
            spec_d  = is_special;
            spres_d = special_res;
`ifdef MD_DIV_FASTPATH_EN
            if (is_special) begin
              result_d = special_res;
              valid_d  = 1'b1;
              state_d  = DONE;
            end else
`endif
            begin
              quo_d   = abs_a;
              b_d     = abs_b;
              qneg_d  = div_signed & (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
              rneg_d  = div_signed & rs1_val[XLEN-1];
              rem_d   = '0;
              cnt_d   = '0;
              state_d = DIV;
            end
          end
        end
      end
      MUL: begin
        result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          // Special cases that ran the full loop still report the exact value.
          if (spec_q)       result_d = spres_q;
          else if (op_q[1]) result_d = rem_fix;
          else              result_d = quo_fix;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d  = IDLE;
      valid_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
      spres_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      spec_q   <= spec_d;
      spres_q  <= spres_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign md_stall  = md_req & ~flush & ~valid_q;
  assign md_busy   = (state_q != IDLE);
  assign md_valid  = valid_q;
  assign md_result = result_q;

endmodule
